// File: rtl/mfe_pkg.sv
// mfe_pkg: shared types and sizing helpers for the median-filter host memory
package mfe_pkg;
  localparam int DW = 8;
  localparam int AW = 14;
  typedef enum logic [2:0] {LOAD, START, RUN, DRAIN, DONE} state_e;
  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction
endpackage

// File: rtl/mfe_byte_ram.sv
// mfe_byte_ram: one-write/one-read byte RAM, read-first, 0 or 1 cycle read latency
module mfe_byte_ram #(
  parameter int AW       = 14,
  parameter int DW       = 8,
  parameter int DEPTH    = 16384,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd, rd_q;
  // addresses beyond the frame read as zero
  always_comb rd = ({1'b0, raddr_i} < DEP) ? mem[raddr_i] : '0;
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_q <= '0;
    else rd_q <= rd;
  always_comb rdata_o = (READ_LAT != 0) ? rd_q : rd;
endmodule

// File: rtl/mfe_host_mem.sv
// mfe_host_mem: loads a frame, serves the engine's image reads and result writes,
// then streams the result buffer out in address order
module mfe_host_mem import mfe_pkg::*; #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int AW       = mfe_pkg::AW,
  parameter int DW       = mfe_pkg::DW,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_wr,
  input  logic          wen,
  output logic [DW-1:0] data_rd,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          done,
  output logic          err
);
  localparam int          NPIX = npix(IMG_W, IMG_H);
  localparam logic [AW:0] NP   = (AW+1)'(NPIX);
  localparam logic [AW:0] LAST = (AW+1)'(NPIX - 1);
  localparam bit          LAT1 = READ_LAT != 0;
  state_e        state_q, state_d;
  logic [AW:0]   ld_cnt_q, ld_cnt_d, rd_cnt_q, rd_cnt_d;
  logic          err_q, err_d, run, drain, ld_last, rd_last, res_we;
  logic [AW-1:0] rd_sel, res_raddr;
  logic [DW-1:0] img_rd, res_rd;
  always_comb begin
    run      = state_q == RUN;
    drain    = state_q == DRAIN;
    ld_last  = ld_cnt_q == LAST;
    rd_last  = rd_cnt_q == LAST;
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      LOAD: if (load_valid) begin
        ld_cnt_d = ld_last ? '0 : ld_cnt_q + 1'b1;
        state_d  = ld_last ? START : LOAD;
      end
      START: state_d = busy ? RUN : START;
      RUN:   state_d = busy ? RUN : DRAIN;
      DRAIN: if (out_ready) begin
        rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
        state_d  = rd_last ? DONE : DRAIN;
      end
      DONE: begin
        state_d  = LOAD;
        ld_cnt_d = '0;
        rd_cnt_d = '0;
      end
      default: state_d = LOAD;
    endcase
    err_d  = err_q | (wen & (~run | ({1'b0, addr} >= NP)));
    res_we = run & wen & ({1'b0, addr} < NP);
    // registered reads fetch the next pixel ahead so out_data is valid with out_valid
    rd_sel    = (LAT1 && drain) ? rd_cnt_d[AW-1:0] : rd_cnt_q[AW-1:0];
    res_raddr = (drain || (LAT1 && run && !busy)) ? rd_sel : addr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= LOAD;
      ld_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  mfe_byte_ram #(.AW(AW), .DW(DW), .DEPTH(NPIX), .READ_LAT(READ_LAT)) u_img (
    .clk(clk), .rst(rst), .we_i(load_valid && state_q == LOAD), .waddr_i(ld_cnt_q[AW-1:0]),
    .wdata_i(load_data), .raddr_i(iaddr), .rdata_o(img_rd)
  );
  mfe_byte_ram #(.AW(AW), .DW(DW), .DEPTH(NPIX), .READ_LAT(READ_LAT)) u_res (
    .clk(clk), .rst(rst), .we_i(res_we), .waddr_i(addr),
    .wdata_i(data_wr), .raddr_i(res_raddr), .rdata_o(res_rd)
  );
  always_comb begin
    load_ready = state_q == LOAD;
    ready      = state_q == START;
    out_valid  = drain;
    done       = state_q == DONE;
    err        = err_q;
    idata      = run ? img_rd : '0;
    data_rd    = run ? res_rd : '0;
    out_data   = drain ? res_rd : '0;
  end
endmodule

// File: tb/tb_mfe_host_mem.sv
// tb_mfe_host_mem: directed bench driving a 4x4 frame through both read latencies in lockstep
module tb_mfe_host_mem;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 16;
  logic          clk = 0, rst = 1, load_valid = 0, busy = 0, wen = 0, out_ready = 0;
  logic [DW-1:0] load_data = '0, data_wr = '0;
  logic [AW-1:0] iaddr = '0, addr = '0;
  logic          load_ready [2], ready [2], out_valid [2], done [2], err [2];
  logic [DW-1:0] idata [2], data_rd [2], out_data [2];
  int            n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mfe_host_mem #(.IMG_W(4), .IMG_H(4), .AW(AW), .DW(DW), .READ_LAT(g)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready[g]), .ready(ready[g]), .busy(busy), .iaddr(iaddr),
      .idata(idata[g]), .addr(addr), .data_wr(data_wr), .wen(wen), .data_rd(data_rd[g]),
      .out_valid(out_valid[g]), .out_data(out_data[g]), .out_ready(out_ready),
      .done(done[g]), .err(err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_img(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(i);
      step;
      if (gaps && i[0]) begin
        load_valid = 1'b0;
        step;
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic start_eng(input int w);
    for (int k = 0; k <= w; k++) begin
      busy = (k == w);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("start_ready%0d_c%0d", g, k), 32'(ready[g]), 32'd1);
        if (k == 0) chk($sformatf("start_lr%0d", g), 32'(load_ready[g]), 32'd0);
      end
      step;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("run_ready%0d", g), 32'(ready[g]), 32'd0);
  endtask

  task automatic write_res(input logic [7:0] x);
    for (int i = 0; i < N; i++) begin
      wen     = 1'b1;
      addr    = AW'(i);
      data_wr = 8'(i) ^ x;
      step;
    end
    wen = 1'b0;
  endtask

  task automatic drain(input logic [7:0] x, input int stop, input bit rnd);
    int idx = 0, guard = 0;
    busy = 1'b0;
    step;
    while (idx < stop && guard < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("drain_ov%0d_%0d", g, idx), 32'(out_valid[g]), 32'd1);
        chk($sformatf("drain_od%0d_%0d", g, idx), 32'(out_data[g]), 32'(idx) ^ 32'(x));
      end
      if (out_ready) idx++;
      guard++;
      step;
    end
    if (guard >= 300) chk("drain_timeout", 32'(idx), 32'(stop));
    out_ready = 1'b0;
  endtask

  task automatic done_check;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("done_pulse%0d", g), 32'(done[g]), 32'd1);
      chk($sformatf("done_ov%0d", g), 32'(out_valid[g]), 32'd0);
    end
    step;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("done_once%0d", g), 32'(done[g]), 32'd0);
      chk($sformatf("rearm_lr%0d", g), 32'(load_ready[g]), 32'd1);
    end
    step;
  endtask

  initial begin
    #12;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_lr%0d", g), 32'(load_ready[g]), 32'd1);
      chk($sformatf("rst_ready%0d", g), 32'(ready[g]), 32'd0);
      chk($sformatf("rst_ov%0d", g), 32'(out_valid[g]), 32'd0);
      chk($sformatf("rst_done%0d", g), 32'(done[g]), 32'd0);
      chk($sformatf("rst_err%0d", g), 32'(err[g]), 32'd0);
      chk($sformatf("rst_idata%0d", g), 32'(idata[g]), 32'd0);
      chk($sformatf("rst_drd%0d", g), 32'(data_rd[g]), 32'd0);
      chk($sformatf("rst_od%0d", g), 32'(out_data[g]), 32'd0);
    end
    rst = 1'b0;
    step;
    // frame 1: gapped load, delayed busy, reads, writes, random-stall drain
    load_img(8'h10, 1'b1);
    start_eng(3);
    iaddr = AW'(7);
    @(negedge clk);
    chk("idata0_a7_same", 32'(idata[0]), 32'h17);
    step;
    @(negedge clk);
    chk("idata0_a7", 32'(idata[0]), 32'h17);
    chk("idata1_a7_next", 32'(idata[1]), 32'h17);
    iaddr = AW'(5);
    step;
    @(negedge clk);
    chk("idata0_a5", 32'(idata[0]), 32'h15);
    chk("idata1_a5", 32'(idata[1]), 32'h15);
    iaddr = AW'(20);
    @(negedge clk);
    chk("idata0_a20", 32'(idata[0]), 32'h0);
    step;
    @(negedge clk);
    chk("idata1_a20", 32'(idata[1]), 32'h0);
    wen = 1'b1; addr = AW'(3); data_wr = 8'h11;
    step;
    data_wr = 8'hA5;
    step;
    wen = 1'b0;
    @(negedge clk);
    chk("drd0_a3", 32'(data_rd[0]), 32'hA5);
    chk("drd1_readfirst", 32'(data_rd[1]), 32'h11);
    step;
    @(negedge clk);
    chk("drd1_a3", 32'(data_rd[1]), 32'hA5);
    for (int g = 0; g < 2; g++) chk($sformatf("err_pre%0d", g), 32'(err[g]), 32'd0);
    wen = 1'b1; addr = AW'(16); data_wr = 8'h77;
    step;
    wen = 1'b0; addr = AW'(3);
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("err_oob%0d", g), 32'(err[g]), 32'd1);
    chk("drd0_after_oob", 32'(data_rd[0]), 32'hA5);
    step;
    write_res(8'hFF);
    drain(8'hFF, N, 1'b1);
    done_check;
    // frame 2: reset in the middle of the drain
    load_img(8'h20, 1'b0);
    start_eng(0);
    write_res(8'h5A);
    drain(8'h5A, 6, 1'b0);
    for (int g = 0; g < 2; g++) chk($sformatf("err_sticky%0d", g), 32'(err[g]), 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("mid_rst_ov%0d", g), 32'(out_valid[g]), 32'd0);
      chk($sformatf("mid_rst_err%0d", g), 32'(err[g]), 32'd0);
      chk($sformatf("mid_rst_lr%0d", g), 32'(load_ready[g]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    step;
    // frame 3: full frame after reset
    load_img(8'h30, 1'b1);
    start_eng(2);
    iaddr = AW'(5);
    step;
    @(negedge clk);
    chk("f3_idata0", 32'(idata[0]), 32'h35);
    chk("f3_idata1", 32'(idata[1]), 32'h35);
    step;
    write_res(8'hC3);
    drain(8'hC3, N, 1'b1);
    done_check;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mfe_host_mem.md
Name: mfe_host_mem

Overview:
- Host-side responder for the median-filter engine's memory interface.
- Loads a grayscale image from a byte stream into an internal image buffer, then raises ready to start the engine.
- Serves the engine's image reads (iaddr/idata) and captures its result writes (addr/data_wr/wen) into a result buffer, which the engine can read back on data_rd.
- When the engine drops busy, streams the result buffer out in address order, then re-arms for the next frame.

Parameters:
- IMG_W, 128, image width in pixels.
- IMG_H, 128, image height in pixels.
- AW, 14, address width; 2**AW must be >= IMG_W*IMG_H.
- DW, 8, pixel width.
- READ_LAT, 1, read latency of idata/data_rd in cycles; legal values 0 (combinational) or 1 (registered).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- load_valid  in  1  input pixel stream valid.
- load_data  in  DW  input pixel, raster order.
- load_ready  out  1  stream ready; high only in LOAD.
- ready  out  1  to engine; image available, start request.
- busy  in  1  from engine; engine is processing.
- iaddr  in  AW  image read address from engine.
- idata  out  DW  image read data to engine.
- addr  in  AW  result address from engine.
- data_wr  in  DW  result write data.
- wen  in  1  result write enable.
- data_rd  out  DW  result read data at addr.
- out_valid  out  1  result stream valid.
- out_data  out  DW  result pixel, address order 0..NPIX-1.
- out_ready  in  1  result stream ready.
- done  out  1  one-cycle pulse after the last result pixel is accepted.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- NPIX = IMG_W*IMG_H. States: LOAD, START, RUN, DRAIN, DONE.
- Reset values: state=LOAD, counters=0, ready=0, out_valid=0, done=0, err=0, idata=0, data_rd=0, out_data=0. Buffer contents are not reset.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid&load_ready writes load_data to image[ld_cnt], then ld_cnt++.
  - The NPIX-th accepted byte sets ld_cnt=0 and moves to START next cycle.
- START:
  - ready=1, held until busy is sampled 1; then RUN with ready=0 on the following edge.
  - busy already 1 on entry means RUN after exactly one ready cycle.
- RUN:
  - idata = image[iaddr] (READ_LAT=0) or image[iaddr] registered (READ_LAT=1, valid the cycle after iaddr).
  - iaddr >= NPIX returns 0.
  - wen=1 with addr < NPIX writes data_wr to result[addr] at the clock edge.
  - wen=1 with addr >= NPIX drops the write and sets err.
  - data_rd = result[addr] with the same READ_LAT rule. Read-first: a same-cycle write to the same addr does not appear until the next read.
  - busy falling 1->0 moves to DRAIN.
  - wen in any state other than RUN is ignored and sets err.
- DRAIN:
  - out_valid=1; out_data = result[rd_cnt], prefetched so out_data is valid whenever out_valid=1 regardless of READ_LAT.
  - out_valid&out_ready advances rd_cnt.
  - Stall holds out_data stable.
  - Acceptance of pixel NPIX-1 moves to DONE.
- DONE: done=1 for one cycle; counters cleared; next state LOAD.
- load_valid outside LOAD is not accepted (load_ready=0); the data stays pending at the source.
- Asynchronous rst in any state returns to LOAD within the reset. An engine still busy is not signalled; the system resets both blocks together.
- Counters are AW+1 bits wide; comparisons are against NPIX, so no wrap for NPIX = 2**AW.

Decomposition:
- Package mfe_pkg: state enum (LOAD, START, RUN, DRAIN, DONE), DW, AW, NPIX localparam function.
- Sub-module mfe_byte_ram: one write port, one read port, READ_LAT parameter, read-first. Instantiated twice (image, result).
- Top holds only the FSM, counters and the err flag.

Test Plan (IMG_W=4, IMG_H=4, NPIX=16, both READ_LAT values):
- Load bytes 0x10..0x1F with load_valid gaps -> load_ready drops after the 16th byte; ready rises next cycle; image[5]=0x15.
- Hold busy=0 for 3 cycles in START, then busy=1 -> ready stays 1 for 4 cycles, then 0; state RUN.
- In RUN, iaddr=7 -> idata=0x17 (same cycle for LAT 0, next cycle for LAT 1); iaddr=20 -> idata=0.
- wen with addr=3, data_wr=0xA5, then read addr=3 -> data_rd=0xA5 on the following read; wen with addr=16 -> err=1 and no write.
- Write result[i]=i^0xFF, drop busy, toggle out_ready randomly -> out_data sequence 0xFF..0xF0 with no skips or repeats; done pulses once; load_ready=1 next cycle.
- Assert rst mid-DRAIN at rd_cnt=6 -> out_valid=0, err=0, state LOAD immediately; a new frame completes correctly.
